// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the multi-digit code lock.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned min1_clog2(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Factory code digit i is a walking one modulo the digit width.
    function automatic logic [31:0] default_code(input int unsigned i, input int unsigned code_w);
        return 32'(1) << (i % code_w);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout countdown: loadable down-counter with a zero flag.
module lock_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/code_sequence_lock.sv
// Multi-digit code lock with failed-try lockout and in-place reprogramming while open.
module code_sequence_lock
    import code_lock_pkg::*;
#(
    parameter int unsigned CODE_W      = 3,
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    localparam int unsigned IDX_W      = min1_clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] codein,
    input  logic              enter,
    input  logic              program_en,
    input  logic              clear,
    output logic              unlock,
    output logic              error,
    output logic              locked_out,
    output logic              prog_done,
    output logic [IDX_W-1:0]  digit_idx
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TIMER_W = min1_clog2(LOCKOUT_CYC);

    lock_state_t        state_q, state_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic               mism_q, mism_nxt;
    logic [TRIES_W-1:0] tries_q, tries_nxt;
    logic [CODE_W-1:0]  store_q [DIGITS];

    logic store_we;
    logic error_nxt;
    logic prog_done_nxt;
    logic timer_load;
    logic timer_dec;
    logic timer_zero_c;
    logic digit_miss;
    logic last_digit;

    lock_timer #(
        .W (TIMER_W)
    ) u_lock_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (TIMER_W'(LOCKOUT_CYC - 1)),
        .dec      (timer_dec),
        .zero_c   (timer_zero_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ENTRY;
            idx_q      <= '0;
            mism_q     <= 1'b0;
            tries_q    <= '0;
            unlock     <= 1'b0;
            error      <= 1'b0;
            locked_out <= 1'b0;
            prog_done  <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                store_q[i] <= CODE_W'(default_code(i, CODE_W));
            end
        end else begin
            state_q    <= state_nxt;
            idx_q      <= idx_nxt;
            mism_q     <= mism_nxt;
            tries_q    <= tries_nxt;
            unlock     <= (state_nxt == ST_OPEN);
            error      <= error_nxt;
            locked_out <= (state_nxt == ST_LOCKOUT);
            prog_done  <= prog_done_nxt;
            if (store_we) begin
                store_q[idx_q] <= codein;
            end
        end
    end

    assign digit_idx = idx_q;

    // Every digit is collected before judging so a failure never reveals its position.
    always_comb begin
        state_nxt     = state_q;
        idx_nxt       = idx_q;
        mism_nxt      = mism_q;
        tries_nxt     = tries_q;
        store_we      = 1'b0;
        error_nxt     = 1'b0;
        prog_done_nxt = 1'b0;
        timer_load    = 1'b0;
        timer_dec     = 1'b0;
        digit_miss    = (codein != store_q[idx_q]);
        last_digit    = (idx_q == IDX_W'(DIGITS - 1));

        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    idx_nxt  = '0;
                    mism_nxt = 1'b0;
                end else if (enter) begin
                    if (last_digit) begin
                        idx_nxt  = '0;
                        mism_nxt = 1'b0;
                        if (!(mism_q || digit_miss)) begin
                            state_nxt = ST_OPEN;
                            tries_nxt = '0;
                        end else begin
                            error_nxt = 1'b1;
                            if ((32'(tries_q) + 32'd1) == 32'(MAX_TRIES)) begin
                                state_nxt  = ST_LOCKOUT;
                                timer_load = 1'b1;
                                tries_nxt  = '0;
                            end else begin
                                tries_nxt = tries_q + TRIES_W'(1);
                            end
                        end
                    end else begin
                        idx_nxt  = idx_q + IDX_W'(1);
                        mism_nxt = mism_q | digit_miss;
                    end
                end
            end

            ST_OPEN: begin
                if (clear) begin
                    idx_nxt  = '0;
                    mism_nxt = 1'b0;
                end else if (enter) begin
                    if (program_en) begin
                        store_we = 1'b1;
                        if (last_digit) begin
                            idx_nxt       = '0;
                            prog_done_nxt = 1'b1;
                            state_nxt     = ST_ENTRY;
                        end else begin
                            idx_nxt = idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_nxt = ST_ENTRY;
                        idx_nxt   = '0;
                        mism_nxt  = 1'b0;
                    end
                end
            end

            ST_LOCKOUT: begin
                timer_dec = 1'b1;
                if (timer_zero_c) begin
                    state_nxt = ST_ENTRY;
                end
            end

            default: begin
                state_nxt = ST_ENTRY;
                idx_nxt   = '0;
                mism_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_code_sequence_lock.sv
// Directed and random checking of code_sequence_lock against a sequence-level reference model.
module tb_code_sequence_lock;

    localparam int unsigned CODE_W      = 3;
    localparam int unsigned DIGITS      = 3;
    localparam int unsigned MAX_TRIES   = 3;
    localparam int unsigned LOCKOUT_CYC = 16;
    localparam int unsigned IDX_W       = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [CODE_W-1:0] codein;
    logic              enter;
    logic              program_en;
    logic              clear;
    logic              unlock;
    logic              error;
    logic              locked_out;
    logic              prog_done;
    logic [IDX_W-1:0]  digit_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: the code, the digits typed so far, and plain counters.
    int m_code [DIGITS];
    int m_entered [$];
    int m_pos;
    bit m_open;
    int m_lock_left;
    int m_tries;
    bit m_error;
    bit m_prog_done;

    code_sequence_lock #(
        .CODE_W      (CODE_W),
        .DIGITS      (DIGITS),
        .MAX_TRIES   (MAX_TRIES),
        .LOCKOUT_CYC (LOCKOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .codein     (codein),
        .enter      (enter),
        .program_en (program_en),
        .clear      (clear),
        .unlock     (unlock),
        .error      (error),
        .locked_out (locked_out),
        .prog_done  (prog_done),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < int'(DIGITS); i++) m_code[i] = 1 << (i % int'(CODE_W));
        m_entered.delete();
        m_pos       = 0;
        m_open      = 1'b0;
        m_lock_left = 0;
        m_tries     = 0;
        m_error     = 1'b0;
        m_prog_done = 1'b0;
    endfunction

    function automatic void model_step(bit c, bit e, bit p, int d);
        bit match;
        m_error     = 1'b0;
        m_prog_done = 1'b0;
        if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (m_open) begin
            if (c) begin
                m_pos = 0;
            end else if (e && p) begin
                m_code[m_pos] = d;
                m_pos++;
                if (m_pos == int'(DIGITS)) begin
                    m_pos       = 0;
                    m_prog_done = 1'b1;
                    m_open      = 1'b0;
                end
            end else if (e) begin
                m_open = 1'b0;
                m_pos  = 0;
            end
        end else begin
            if (c) begin
                m_entered.delete();
            end else if (e) begin
                m_entered.push_back(d);
                if (m_entered.size() == int'(DIGITS)) begin
                    match = 1'b1;
                    for (int i = 0; i < int'(DIGITS); i++)
                        if (m_entered[i] != m_code[i]) match = 1'b0;
                    m_entered.delete();
                    if (match) begin
                        m_open  = 1'b1;
                        m_pos   = 0;
                        m_tries = 0;
                    end else begin
                        m_error = 1'b1;
                        m_tries++;
                        if (m_tries == int'(MAX_TRIES)) begin
                            m_lock_left = int'(LOCKOUT_CYC);
                            m_tries     = 0;
                        end
                    end
                end
            end
        end
    endfunction

    function automatic int exp_idx();
        if (m_lock_left > 0) return 0;
        if (m_open) return m_pos;
        return m_entered.size();
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("unlock",     32'(unlock),     32'(m_open));
        check("error",      32'(error),      32'(m_error));
        check("locked_out", 32'(locked_out), 32'(m_lock_left > 0));
        check("prog_done",  32'(prog_done),  32'(m_prog_done));
        check("digit_idx",  32'(digit_idx),  32'(exp_idx()));
    endtask

    task automatic step(input bit c, input bit e, input bit p, input int d);
        clear      = c;
        enter      = e;
        program_en = p;
        codein     = CODE_W'(d);
        @(posedge clk);
        model_step(c, e, p, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0; enter = 1'b0; program_en = 1'b0; codein = '0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        check_all();
    endtask

    task automatic seq(input int a, input int b, input int c, input bit p);
        step(1'b0, 1'b1, p, a);
        step(1'b0, 1'b1, p, b);
        step(1'b0, 1'b1, p, c);
    endtask

    initial begin
        int lock_cnt;
        int d;
        bit e;
        bit p;
        bit c;
        reset = 1'b1; clear = 1'b0; enter = 1'b0; program_en = 1'b0; codein = '0;

        // Reset values
        do_reset();
        check("reset_unlock", 32'(unlock), 32'd0);

        // Default code opens; relock with a plain enter
        seq(1, 2, 4, 1'b0);
        check("default_unlock", 32'(unlock), 32'd1);
        step(1'b0, 1'b1, 1'b0, 0);
        check("relock", 32'(unlock), 32'd0);

        // Wrong middle digit: error once, index back to zero
        step(1'b0, 1'b1, 1'b0, 1);
        step(1'b0, 1'b1, 1'b0, 3);
        check("no_early_err", 32'(error), 32'd0);
        step(1'b0, 1'b1, 1'b0, 4);
        check("wrong_err", 32'(error), 32'd1);
        check("wrong_idx", 32'(digit_idx), 32'd0);
        step(1'b0, 1'b0, 1'b0, 0);

        // Two more failures trigger a lockout of exactly LOCKOUT_CYC cycles
        seq(0, 0, 0, 1'b0);
        seq(7, 7, 7, 1'b0);
        lock_cnt = 0;
        while (locked_out && lock_cnt < 64) begin
            lock_cnt++;
            step(1'b0, 1'b1, 1'b0, lock_cnt % 8);
        end
        check("lockout_len", 32'(lock_cnt), 32'(LOCKOUT_CYC));
        seq(1, 2, 4, 1'b0);
        check("post_lock_unlock", 32'(unlock), 32'd1);

        // Reprogram to 7,0,5
        seq(7, 0, 5, 1'b1);
        check("prog_done", 32'(prog_done), 32'd1);
        check("prog_relock", 32'(unlock), 32'd0);
        seq(1, 2, 4, 1'b0);
        check("old_code_fails", 32'(error), 32'd1);
        seq(7, 0, 5, 1'b0);
        check("new_code_unlock", 32'(unlock), 32'd1);

        // Clear beats same-cycle enter, and no try is counted
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 1);
        check("clear_idx", 32'(digit_idx), 32'd0);
        seq(1, 2, 4, 1'b0);
        check("clear_unlock", 32'(unlock), 32'd1);
        step(1'b0, 1'b1, 1'b0, 0);
        seq(0, 0, 0, 1'b0);
        seq(0, 0, 0, 1'b0);
        check("two_fail_no_lock", 32'(locked_out), 32'd0);
        seq(0, 0, 0, 1'b0);
        check("third_fail_lock", 32'(locked_out), 32'd1);

        // Reset mid-programming restores the factory code
        do_reset();
        seq(1, 2, 4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6);
        do_reset();
        seq(1, 2, 4, 1'b0);
        check("reset_restores", 32'(unlock), 32'd1);

        // Random traffic, digits biased toward the live code
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                c = ($urandom_range(0, 19) == 0);
                e = ($urandom_range(0, 1) == 1);
                p = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) != 0)
                    d = m_code[m_open ? m_pos : (m_entered.size() % int'(DIGITS))];
                else
                    d = int'($urandom_range(0, 7));
                if (m_open && p && $urandom_range(0, 1) == 1)
                    d = int'($urandom_range(0, 7));
                step(c, e, p, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
